// File: rtl/mul8_nibble_seq_if.sv
// Request/result handshake bundle for the nibble-serial 8x8 multiplier.
interface mul8_nibble_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] result;
    logic        busy;

    modport master (
        output req_valid, a, b, res_ready,
        input  req_ready, res_valid, result, busy
    );

    modport slave (
        input  req_valid, a, b, res_ready,
        output req_ready, res_valid, result, busy
    );
endinterface

// File: rtl/mul8_nibble_seq.sv
// 8x8 unsigned multiplier built from up to four passes through a shared external 4x4 multiplier.
// Latency: popcount(step mask) cycles after accept; result held in DONE until res_ready.
module mul8_nibble_seq #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    mul8_nibble_seq_if.slave   bus,
    output logic [3:0]         mul_m,
    output logic [3:0]         mul_q,
    input  logic [7:0]         mul_p
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] acc, acc_nxt;
    logic [1:0]  step, step_nxt;
    logic [3:0]  mask, mask_nxt;
    logic [7:0]  a_r, a_nxt;
    logic [7:0]  b_r, b_nxt;

    logic [3:0]  nib_m, nib_q;
    logic [15:0] pp_shifted;
    logic [3:0]  mask_in;
    logic [2:0]  first_in;
    logic [2:0]  next_in;

    // Returns {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [2:0] next_set(input logic [3:0] m, input int from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i >= from)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    // Step order: 0=(aL,bL) 1=(aH,bL) 2=(aL,bH) 3=(aH,bH); bit0 picks a's nibble, bit1 picks b's.
    always_comb begin
        nib_m = step[0] ? a_r[7:4] : a_r[3:0];
        nib_q = step[1] ? b_r[7:4] : b_r[3:0];
        case (step)
            2'd0:    pp_shifted = {8'h00, mul_p};
            2'd3:    pp_shifted = {mul_p, 8'h00};
            default: pp_shifted = {4'h0, mul_p, 4'h0};
        endcase
    end

    always_comb begin
        mask_in[0] = !SKIP_ZERO || ((|bus.a[3:0]) && (|bus.b[3:0]));
        mask_in[1] = !SKIP_ZERO || ((|bus.a[7:4]) && (|bus.b[3:0]));
        mask_in[2] = !SKIP_ZERO || ((|bus.a[3:0]) && (|bus.b[7:4]));
        mask_in[3] = !SKIP_ZERO || ((|bus.a[7:4]) && (|bus.b[7:4]));
        first_in   = next_set(mask_in, 0);
        next_in    = next_set(mask, int'(step) + 1);
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        step_nxt  = step;
        mask_nxt  = mask;
        a_nxt     = a_r;
        b_nxt     = b_r;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    a_nxt    = bus.a;
                    b_nxt    = bus.b;
                    acc_nxt  = 16'h0000;
                    mask_nxt = mask_in;
                    step_nxt = first_in[1:0];
                    state_nxt = first_in[2] ? CALC : DONE;
                end
            end
            CALC: begin
                acc_nxt = acc + pp_shifted;
                if (next_in[2]) begin
                    step_nxt = next_in[1:0];
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= 16'h0000;
            step  <= 2'd0;
            mask  <= 4'h0;
            a_r   <= 8'h00;
            b_r   <= 8'h00;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            step  <= step_nxt;
            mask  <= mask_nxt;
            a_r   <= a_nxt;
            b_r   <= b_nxt;
        end
    end

    // The shared multiplier only sees live operands while a step is executing.
    assign mul_m         = (state == CALC) ? nib_m : 4'h0;
    assign mul_q         = (state == CALC) ? nib_q : 4'h0;
    assign bus.req_ready = (state == IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = acc;

endmodule

// File: tb/tb_mul8_nibble_seq.sv
// Directed and random checks of mul8_nibble_seq with both SKIP_ZERO settings.
module tb_mul8_nibble_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul8_nibble_seq_if bus0 ();
    mul8_nibble_seq_if bus1 ();

    logic [3:0] m0, q0, m1, q1;
    logic [7:0] p0, p1;
    assign p0 = {4'h0, m0} * {4'h0, q0};
    assign p1 = {4'h0, m1} * {4'h0, q1};

    mul8_nibble_seq #(.SKIP_ZERO(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .mul_m(m0), .mul_q(q0), .mul_p(p0)
    );
    mul8_nibble_seq #(.SKIP_ZERO(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .mul_m(m1), .mul_q(q1), .mul_p(p1)
    );

    logic       sel;
    logic       req_valid, res_ready;
    logic [7:0] a, b;

    assign bus0.req_valid = req_valid & ~sel;
    assign bus1.req_valid = req_valid & sel;
    assign bus0.a = a;
    assign bus1.a = a;
    assign bus0.b = b;
    assign bus1.b = b;
    assign bus0.res_ready = res_ready;
    assign bus1.res_ready = res_ready;

    wire        o_req_ready = sel ? bus1.req_ready : bus0.req_ready;
    wire        o_res_valid = sel ? bus1.res_valid : bus0.res_valid;
    wire        o_busy      = sel ? bus1.busy      : bus0.busy;
    wire [15:0] o_result    = sel ? bus1.result    : bus0.result;
    wire [3:0]  o_m         = sel ? m1 : m0;
    wire [3:0]  o_q         = sel ? q1 : q0;

    int errors = 0;
    int checks = 0;
    logic [15:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res_valid"}, o_res_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_result"}, o_result, 0);
        chk({tag, "_mul_m"}, o_m, 0);
        chk({tag, "_mul_q"}, o_q, 0);
    endtask

    // n_exp < 0 means "take the CALC count from the step model"; bp = DONE cycles with res_ready low.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input int n_exp, input int bp);
        logic [3:0]  em[$];
        logic [3:0]  eq[$];
        logic [3:0]  sm, sq;
        logic [15:0] expr;
        int          cnt, n_want;
        bit          skip;
        skip = (sel == 1'b0);
        for (int s = 0; s < 4; s++) begin
            sm = ((s % 2) == 1) ? ia[7:4] : ia[3:0];
            sq = (s >= 2)       ? ib[7:4] : ib[3:0];
            if (!skip || (sm != 4'h0 && sq != 4'h0)) begin
                em.push_back(sm);
                eq.push_back(sq);
            end
        end
        n_want = (n_exp >= 0) ? n_exp : em.size();
        sb.push_back(16'(ia) * 16'(ib));

        chk("idle_req_ready", o_req_ready, 1);
        req_valid = 1'b1;
        a = ia;
        b = ib;
        @(negedge clk);
        req_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);

        cnt = 0;
        while (!o_res_valid && cnt < 12) begin
            chk("calc_busy", o_busy, 1);
            chk("calc_req_ready", o_req_ready, 0);
            if (cnt < em.size()) begin
                chk("calc_mul_m", o_m, em[cnt]);
                chk("calc_mul_q", o_q, eq[cnt]);
            end
            cnt++;
            @(negedge clk);
        end
        chk("calc_cycles", cnt, n_want);
        expr = sb.pop_front();
        if (!o_res_valid) begin
            chk("res_valid_timeout", o_res_valid, 1);
            return;
        end
        chk("done_busy", o_busy, 1);
        chk("done_req_ready", o_req_ready, 0);
        chk("done_mul_m", o_m, 0);
        chk("done_mul_q", o_q, 0);
        chk("result", o_result, expr);

        if (bp > 0) begin
            res_ready = 1'b0;
            req_valid = 1'b1;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk("bp_res_valid", o_res_valid, 1);
                chk("bp_busy", o_busy, 1);
                chk("bp_req_ready", o_req_ready, 0);
                chk("bp_result", o_result, expr);
            end
            req_valid = 1'b0;
            res_ready = 1'b1;
        end
        @(negedge clk);
        chk("after_req_ready", o_req_ready, 1);
        chk("after_res_valid", o_res_valid, 0);
        chk("after_busy", o_busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b1;
        a = 8'h00;
        b = 8'h00;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_skip1");
        sel = 1'b1;
        #1;
        chk_all_zero("reset_skip0");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", o_req_ready, 1);

        do_op(8'hFF, 8'hFF, 4, 0);
        do_op(8'h30, 8'h05, 1, 0);
        do_op(8'h00, 8'h7A, 0, 0);
        sel = 1'b1;
        #1;
        do_op(8'h30, 8'h05, 4, 0);
        sel = 1'b0;
        #1;
        do_op(8'hC3, 8'h5A, 4, 3);

        // Abort in the second CALC cycle of 0xFF*0xFF.
        chk("abort_idle_req_ready", o_req_ready, 1);
        req_valid = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_calc1_busy", o_busy, 1);
        @(negedge clk);
        chk("abort_calc2_busy", o_busy, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("abort_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", o_req_ready, 1);
        chk("abort_res_valid", o_res_valid, 0);
        do_op(8'h12, 8'h34, 4, 0);

        for (int i = 0; i < 8; i++) begin
            sel = (i % 2) == 1;
            #1;
            do_op(8'($urandom), 8'($urandom), -1, i % 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
